// File: rtl/selectable_demux8.sv
// -----------------------------------------------------------------------------
// selectable_demux8
//
// Steers a signed 16-bit sample to one of eight registered channel outputs.
// Every channel switch passes through a blanking interval. During blanking all
// outputs hold, and the previously live channel stays frozen. When blanking
// ends, the old channel is parked and the new channel starts tracking `in` on
// the following edge. A request for channel 8..63 drops the block to idle.
//
// Parameters
//   HOLD_CYCLES : blanking length in clk cycles (0..255); 0 and 1 both give a
//                 single blanking cycle.
//   PARK_ZERO   : 1 -> deselected outputs are driven to 0,
//                 0 -> deselected outputs keep their last value.
//
// Ports
//   clk        in   rising-edge system clock
//   rst_n      in   asynchronous active-low reset
//   sel[5:0]   in   channel request (0..7 valid, 8..63 = no channel)
//   in[15:0]   in   signed sample
//   out0..out7 out  registered signed channel outputs
//   ch[2:0]    out  live channel index (meaningful while active=1)
//   active     out  a channel is live
//   busy       out  blanking in progress
//   dbg_state  out  FSM state (0 idle, 1 blank, 2 live) for observation
// -----------------------------------------------------------------------------
module selectable_demux8 #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter bit          PARK_ZERO   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         sel,
  input  logic signed [15:0] in,
  output logic signed [15:0] out0,
  output logic signed [15:0] out1,
  output logic signed [15:0] out2,
  output logic signed [15:0] out3,
  output logic signed [15:0] out4,
  output logic signed [15:0] out5,
  output logic signed [15:0] out6,
  output logic signed [15:0] out7,
  output logic [2:0]         ch,
  output logic               active,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_LIVE  = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_LD = HOLD_CYCLES[7:0];

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [2:0]         tgt_q, tgt_d;
  logic [2:0]         ch_q, ch_d;
  logic [5:0]         sel_q, sel_d;
  logic signed [15:0] out_q [8];
  logic signed [15:0] out_d [8];

  logic               sel_chg;
  logic               sel_ok;
  logic [2:0]         sel_idx;
  logic signed [15:0] park_val;

  always_comb begin
    sel_chg  = (sel != sel_q);
    sel_ok   = (sel < 6'd8);
    sel_idx  = sel[2:0];
    // Value the current channel takes when it stops being live.
    park_val = PARK_ZERO ? 16'sd0 : out_q[ch_q];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    ch_d    = ch_q;
    sel_d   = sel;
    out_d   = out_q;

    case (state_q)
      S_IDLE: begin
        // Idle is only entered on an invalid request, so any valid sel seen
        // here is a fresh request (reset also preloads sel_q with 63).
        if (sel_ok) begin
          state_d = S_BLANK;
          cnt_d   = HOLD_LD;
          tgt_d   = sel_idx;
        end
      end

      S_BLANK: begin
        if (sel_chg && !sel_ok) begin
          state_d     = S_IDLE;
          cnt_d       = 8'd0;
          out_d[ch_q] = park_val;
        end else if (sel_chg) begin
          cnt_d = HOLD_LD;
          tgt_d = sel_idx;
        end else if (cnt_q <= 8'd1) begin
          // The count is at its last step, so it reaches 0 on this edge.
          // Loads of 0 and 1 therefore both give a single blanking cycle.
          state_d     = S_LIVE;
          cnt_d       = 8'd0;
          out_d[ch_q] = park_val;
          ch_d        = tgt_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_LIVE: begin
        if (sel_chg && !sel_ok) begin
          state_d     = S_IDLE;
          out_d[ch_q] = park_val;
        end else if (sel_chg && (sel_idx != ch_q)) begin
          // The live channel is not written on this edge, so it freezes.
          state_d = S_BLANK;
          cnt_d   = HOLD_LD;
          tgt_d   = sel_idx;
        end else begin
          out_d[ch_q] = in;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      tgt_q   <= 3'd0;
      ch_q    <= 3'd0;
      sel_q   <= 6'd63;
      for (int i = 0; i < 8; i++) out_q[i] <= 16'sd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      ch_q    <= ch_d;
      sel_q   <= sel_d;
      for (int i = 0; i < 8; i++) out_q[i] <= out_d[i];
    end
  end

  assign out0      = out_q[0];
  assign out1      = out_q[1];
  assign out2      = out_q[2];
  assign out3      = out_q[3];
  assign out4      = out_q[4];
  assign out5      = out_q[5];
  assign out6      = out_q[6];
  assign out7      = out_q[7];
  assign ch        = ch_q;
  assign active    = (state_q == S_LIVE);
  assign busy      = (state_q == S_BLANK);
  assign dbg_state = state_q;

endmodule
